mem_wait_bridge: RTL and testbench
==================================

// Module: mem_wait_bridge
// PURPOSE
//  Sits between the multi-cycle MIPS core and async_mem. Converts a CPU request/ready
//  handshake into timed mem_read/mem_write strobes. Holds address/data stable for a
//  programmable number of wait cycles so the 7 ns async read settles before it is sampled.
//  Registers the read word. Rejects misaligned accesses without touching memory.
// PARAMETERS
//  READ_WAIT  3   cycles mem_read is held before read data is captured; legal 1..15 (4-bit counter)
//  ADDR_W     32  address width
//  DATA_W     32  data width
// PORTS
//  clk             in   1       rising-edge clock
//  reset_n         in   1       asynchronous, active-low reset
//  cpu_req         in   1       request; CPU holds it high until cpu_ready
//  cpu_we          in   1       1 = write, 0 = read; sampled with cpu_req
//  cpu_addr        in   ADDR_W  byte address; sampled with cpu_req
//  cpu_wdata       in   DATA_W  write data; sampled with cpu_req
//  cpu_rdata       out  DATA_W  registered read data
//  cpu_ready       out  1       one-cycle completion pulse
//  cpu_err         out  1       with cpu_ready: access was misaligned and not performed
//  mem_read        out  1       to async_mem read
//  mem_write       out  1       to async_mem write; memory samples it on posedge clk
//  mem_addr        out  ADDR_W  to async_mem address
//  mem_write_data  out  DATA_W  to async_mem write_data
//  mem_read_data   in   DATA_W  from async_mem read_data
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, cnt=0, cpu_rdata=0, cpu_ready=0, cpu_err=0,
//   mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0. All outputs are registered.
//  States: IDLE, READ, WRITE, RESP, ERR.
//  IDLE: cpu_req=0 -> stay. cpu_req=1 at edge E0 -> latch we/addr/wdata into mem_addr
//   and mem_write_data. Then:
//   - addr[1:0]!=0 -> ERR.
//   - we=0 -> READ, mem_read=1, cnt=READ_WAIT-1.
//   - we=1 -> WRITE, mem_write=1.
//  READ: mem_read and mem_addr held. cnt!=0 -> cnt-1. cnt==0 at edge -> cpu_rdata <= mem_read_data,
//   mem_read=0, -> RESP. mem_read is high for exactly READ_WAIT cycles.
//   Data is captured at E0+READ_WAIT. Read: cpu_ready high in the cycle after that edge.
//  WRITE: one cycle. Memory writes at edge E0+1. mem_write=0, -> RESP. Write: cpu_ready high
//   in the cycle after E0+1.
//  RESP: cpu_ready=1, cpu_err=0 for exactly one cycle, then IDLE. cpu_req is ignored in RESP.
//   A new request is accepted at the first IDLE edge; back-to-back gap is 1 cycle.
//  ERR: cpu_ready=1, cpu_err=1 for one cycle, then IDLE. No mem strobe is ever raised.
//  cpu_req, cpu_addr, cpu_we and cpu_wdata changes while not IDLE are ignored. Latched values govern.
//  cpu_rdata holds its last value until the next successful read. Writes and errors leave it unchanged.
//  Reset mid-READ: strobes drop immediately. cpu_ready is not pulsed.
//  Reset asserted before the WRITE edge: that write does not occur.
//  cnt never wraps: it is loaded only on read entry and stops at 0.
// TESTING
//  1 Preload mem[50]=32'hDEADBEEF; read addr 0xC8 -> mem_read high 3 cycles;
//    cpu_ready at E0+4 with cpu_rdata=DEADBEEF, cpu_err=0.
//  2 Write 0x12345678 to 0xCC, then read 0xCC -> mem_data[51]=12345678 after E0+1;
//    readback returns 12345678.
//  3 Read addr 0xCA -> cpu_ready+cpu_err pulse at E0+2; mem_read/mem_write never high;
//    cpu_rdata unchanged.
//  4 Hold cpu_req high for 3 reads of 0xC8,0xCC,0xD0 -> each ready 1 cycle, exactly
//    1 idle cycle between pulses, data in order.
//  5 Deassert reset_n 1 cycle into a read -> all outputs 0 asynchronously, no ready pulse;
//    release and a read of 0xC8 completes normally.
//  6 READ_WAIT=1 build: read 0xC8 -> mem_read high 1 cycle, ready at E0+2, correct data.

Source files
------------

// File: rtl/mem_wait_bridge.sv
// mem_wait_bridge
// Bridges the multi-cycle MIPS core request/ready handshake onto the
// async_mem strobes. Reads hold mem_read and the address for READ_WAIT
// cycles so the asynchronous read path settles before the word is
// registered. Writes raise mem_write for a single cycle. Misaligned word
// accesses are answered with an error response and never reach memory.
// The request fields are latched when the request is taken in IDLE, so
// later changes on the CPU side are ignored until the FSM returns there.

module mem_wait_bridge #(
    parameter int unsigned READ_WAIT = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Wait counter is loaded with READ_WAIT-1 so that mem_read stays high
    // for exactly READ_WAIT cycles including the entry cycle.
    localparam logic [3:0] CNT_LOAD = 4'(READ_WAIT - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_ready_q;
    logic              cpu_err_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // A word access must have its two low address bits clear.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Request FSM: sequences strobes, wait count, data capture and response pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            cpu_rdata_q <= {DATA_W{1'b0}};
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    cpu_ready_q <= 1'b0;
                    cpu_err_q   <= 1'b0;
                    if (cpu_req) begin
                        mem_addr_q  <= cpu_addr;
                        mem_wdata_q <= cpu_wdata;
                        if (is_misaligned(cpu_addr)) begin
                            state_q <= S_ERR;
                        end else if (!cpu_we) begin
                            state_q    <= S_READ;
                            mem_read_q <= 1'b1;
                            cnt_q      <= CNT_LOAD;
                        end else begin
                            state_q     <= S_WRITE;
                            mem_write_q <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Read path has settled: register the word and drop the strobe.
                        cpu_rdata_q <= mem_read_data;
                        mem_read_q  <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        cpu_err_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end
                end
                S_WRITE: begin
                    // Memory samples mem_write on this edge; the write is done.
                    mem_write_q <= 1'b0;
                    cpu_ready_q <= 1'b1;
                    cpu_err_q   <= 1'b0;
                    state_q     <= S_RESP;
                end
                S_ERR: begin
                    // Mirrors the write cycle timing but with no strobe; the
                    // response pulse that follows carries the error flag.
                    cpu_ready_q <= 1'b1;
                    cpu_err_q   <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    // Response pulse is visible this cycle; requests are ignored here.
                    cpu_ready_q <= 1'b0;
                    cpu_err_q   <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= 4'd0;
                    cpu_ready_q <= 1'b0;
                    cpu_err_q   <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata      = cpu_rdata_q;
    assign cpu_ready      = cpu_ready_q;
    assign cpu_err        = cpu_err_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Bench for mem_wait_bridge: scoreboard of expected responses filled by the
// stimulus side from a word-level memory model, drained by a monitor.
// A second instance built with READ_WAIT=1 gets a short directed read run.

module tb_mem_wait_bridge;

    localparam int RW   = 3;
    localparam int RW_B = 1;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, cpu_err;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic [31:0] b_rdata;
    logic        b_ready, b_err;
    logic        b_mem_read, b_mem_write;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rdy;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          free_at = 0;
    logic [31:0] last_rdata = 32'h0;
    bit          mon_en = 1'b0;

    mem_wait_bridge #(.READ_WAIT(RW), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    mem_wait_bridge #(.READ_WAIT(RW_B), .ADDR_W(32), .DATA_W(32)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(b_req), .cpu_we(b_we), .cpu_addr(b_addr), .cpu_wdata(b_wdata),
        .cpu_rdata(b_rdata), .cpu_ready(b_ready), .cpu_err(b_err),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_write_data(b_mem_wdata), .mem_read_data(b_mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 50) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // Asynchronous read, write sampled on posedge clk.
    assign mem_read_data = mem[mem_addr[9:2]];
    assign b_mem_rdata   = mem[b_mem_addr[9:2]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr[9:2]] = mem_write_data;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: strobe address/data against the live transaction, response against scoreboard.
    int rd_cnt = 0;
    int wr_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (!reset_n || !mon_en) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read || mem_write) begin
                if (sb.size() == 0) begin
                    check("strobe_without_txn", {31'h0, 1'b1}, 32'h0);
                end else begin
                    check("mem_addr", mem_addr, sb[0].addr);
                    if (mem_write) check("mem_write_data", mem_write_data, sb[0].wdata);
                end
            end
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if (cpu_ready) begin
                if (sb.size() == 0) begin
                    check("ready_without_txn", {31'h0, 1'b1}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ready_cycle", 32'(cyc), 32'(e.rdy));
                    check("cpu_err", {31'h0, cpu_err}, {31'h0, e.err});
                    check("cpu_rdata", cpu_rdata, e.rdata);
                    check("read_strobe_cycles", 32'(rd_cnt), 32'(e.nrd));
                    check("write_strobe_cycles", 32'(wr_cnt), 32'(e.nwr));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                check("err_without_ready", {31'h0, cpu_err}, 32'h0);
            end
        end
    end

    // Issue one request (called just after a posedge) and wait for its response.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   e0, lat;
        bit   done;
        e0 = (cyc + 1 > free_at) ? cyc + 1 : free_at;
        e.addr = addr;
        e.wdata = wd;
        if (addr[1:0] != 2'b00) begin
            lat = 2; e.err = 1'b1; e.rdata = last_rdata; e.nrd = 0; e.nwr = 0;
        end else if (we) begin
            lat = 2; e.err = 1'b0; e.rdata = last_rdata; e.nrd = 0; e.nwr = 1;
            ref_mem[addr[9:2]] = wd;
        end else begin
            lat = RW + 1; e.err = 1'b0; e.rdata = ref_mem[addr[9:2]]; e.nrd = RW; e.nwr = 0;
            last_rdata = e.rdata;
        end
        e.rdy   = e0 + lat - 1;
        free_at = e0 + lat + 1;
        sb.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                done = 1'b1;
            end else if (cyc >= e0) begin
                cpu_req   = 1'($urandom);
                cpu_we    = 1'($urandom);
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
        end
        if (!done) begin
            check("ready_timeout", 32'h0, 32'h1);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_rdata"}, cpu_rdata, 32'h0);
        check({name, "_ready_err"}, {30'h0, cpu_ready, cpu_err}, 32'h0);
        check({name, "_strobes"}, {30'h0, mem_read, mem_write}, 32'h0);
        check({name, "_mem_addr"}, mem_addr, 32'h0);
        check({name, "_mem_wdata"}, mem_write_data, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int k, rc, nrd, miss;
        bit got;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        check("reset_b", {b_rdata[0], b_ready, b_err, b_mem_read, b_mem_write}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Aligned read of the preloaded word.
        issue(1'b0, 32'h0000_00C8, 32'h0);
        // Write then read back.
        issue(1'b1, 32'h0000_00CC, 32'h1234_5678);
        check("mem51_after_write", mem[51], 32'h1234_5678);
        issue(1'b0, 32'h0000_00CC, 32'h0);
        // Misaligned read: error, no strobes, read data held.
        issue(1'b0, 32'h0000_00CA, 32'h0);
        idle(2);
        // Back-to-back reads with request held.
        issue(1'b0, 32'h0000_00C8, 32'h0);
        issue(1'b0, 32'h0000_00CC, 32'h0);
        issue(1'b0, 32'h0000_00D0, 32'h0);
        idle(1);

        // Reset one cycle into a read.
        mon_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_00C8;
        @(posedge clk);
        #1;
        check("read_strobe_before_reset", {31'h0, mem_read}, 32'h1);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid_read");
        cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("no_ready_in_reset", {31'h0, cpu_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        free_at = 0; last_rdata = 32'h0; mon_en = 1'b1;
        issue(1'b0, 32'h0000_00C8, 32'h0);

        // Reset before the write edge: memory untouched.
        mon_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_00D4; cpu_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("write_strobe_before_reset", {31'h0, mem_write}, 32'h1);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid_write");
        cpu_req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("aborted_write_mem53", mem[53], ref_mem[53]);
        reset_n = 1'b1;
        free_at = 0; last_rdata = 32'h0; mon_en = 1'b1;

        // Randomized mix with random idle gaps and held requests.
        for (int t = 0; t < 150; t++) begin
            a = {22'h0, 10'($urandom)};
            if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
            issue(1'($urandom), a, $urandom);
            if ($urandom_range(2, 0) == 0) idle($urandom_range(2, 0));
        end
        idle(2);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        miss = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) miss++;
        check("memory_image", 32'(miss), 32'h0);

        // READ_WAIT=1 instance: single-cycle strobe, ready one edge after entry.
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            k = cyc;
            b_req = 1'b1;
            b_addr = 32'h0000_00C8 + 32'(4 * j);
            got = 1'b0; nrd = 0; rc = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (b_mem_read) nrd++;
                if (b_ready) begin
                    got = 1'b1;
                    rc = cyc;
                end
            end
            b_req = 1'b0;
            check("rw1_ready_seen", {31'h0, got}, 32'h1);
            check("rw1_ready_cycle", 32'(rc), 32'(k + 2));
            check("rw1_strobe_cycles", 32'(nrd), 32'h1);
            check("rw1_rdata", b_rdata, ref_mem[50 + j]);
            check("rw1_err", {31'h0, b_err}, 32'h0);
            check("rw1_no_write", {31'h0, b_mem_write}, 32'h0);
            check("rw1_wdata_latched", b_mem_wdata, 32'h0);
            @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
